decode_issue_ctrl: RTL and testbench

Decode/issue controller between instruction fetch and execute. Buffers up to two fetched instructions in a 2-entry queue with valid/ready handshakes on both sides. Extracts register and funct fields and assembles the 12-bit immediate for the downstream immediate generator. Configures the generator's `funct3` select so that only I-type ALU instructions reach its SLTIU/shift special cases. Also supports pipeline flush on redirect and keeps an issued-instruction counter.

---
 rtl/decode_issue_ctrl_if.sv | 33 +++
 rtl/decode_issue_ctrl.sv | 113 +++++++++++
 tb/tb_decode_issue_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_ctrl_if.sv
// rtl/decode_issue_ctrl_if.sv - fetch/execute handshake bundle for decode_issue_ctrl
interface decode_issue_ctrl_if;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [6:0]  ex_opcode;
   logic [4:0]  ex_rd;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic [11:0] ex_imm;
   logic [2:0]  ex_imm_funct3;
   logic        ex_illegal;
   logic [31:0] issue_count;

   modport master (
      output if_valid, if_inst, if_pc, flush, ex_ready,
      input  if_ready, ex_valid, ex_pc, ex_opcode, ex_rd, ex_rs1, ex_rs2,
             ex_funct3, ex_funct7, ex_imm, ex_imm_funct3, ex_illegal, issue_count
   );

   modport slave (
      input  if_valid, if_inst, if_pc, flush, ex_ready,
      output if_ready, ex_valid, ex_pc, ex_opcode, ex_rd, ex_rs1, ex_rs2,
             ex_funct3, ex_funct7, ex_imm, ex_imm_funct3, ex_illegal, issue_count
   );
endinterface

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - two-entry decode/issue queue between fetch and execute
module decode_issue_ctrl #(
   parameter int DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   decode_issue_ctrl_if.slave bus
);
   localparam logic [1:0] FULL = 2'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [11:0] imm;
      logic [2:0]  imm_funct3;
      logic        illegal;
   } entry_t;

   entry_t      mem_q [DEPTH];
   entry_t      mem_d [DEPTH];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] issue_count_q, issue_count_d;

   entry_t      entry_in;
   entry_t      head;
   logic        push;
   logic        pop;

   always_comb begin
      entry_in            = '0;
      entry_in.pc         = bus.if_pc;
      entry_in.opcode     = bus.if_inst[6:0];
      entry_in.rd         = bus.if_inst[11:7];
      entry_in.rs1        = bus.if_inst[19:15];
      entry_in.rs2        = bus.if_inst[24:20];
      entry_in.funct3     = bus.if_inst[14:12];
      entry_in.funct7     = bus.if_inst[31:25];
      // Only I-ALU ops may steer the immediate generator into its shamt/SLTIU paths.
      entry_in.imm_funct3 = (bus.if_inst[6:0] == 7'b0010011) ? bus.if_inst[14:12] : 3'b000;
      case (bus.if_inst[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: entry_in.imm = bus.if_inst[31:20];
         7'b0100011: entry_in.imm = {bus.if_inst[31:25], bus.if_inst[11:7]};
         7'b1100011: entry_in.imm = {bus.if_inst[31], bus.if_inst[7],
                                     bus.if_inst[30:25], bus.if_inst[11:8]};
         7'b0110011: entry_in.imm = 12'h000;
         default:    entry_in.illegal = 1'b1;
      endcase
   end

   assign push = bus.if_valid && (count_q != FULL) && !bus.flush;
   assign pop  = (count_q != 2'd0) && bus.ex_ready;

   always_comb begin
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q ^ push;
      rd_ptr_d      = rd_ptr_q ^ pop;
      count_d       = count_q + {1'b0, push} - {1'b0, pop};
      issue_count_d = issue_count_q + {31'd0, pop};
      if (push) begin
         mem_d[wr_ptr_q] = entry_in;
      end
      // A head popped in the flush cycle still counts; everything else is discarded.
      if (bus.flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q         <= '{default: '0};
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         issue_count_q <= 32'd0;
      end else begin
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         issue_count_q <= issue_count_d;
      end
   end

   always_comb begin
      head = '0;
      if (count_q != 2'd0) begin
         head = mem_q[rd_ptr_q];
      end
   end

   assign bus.if_ready      = (count_q != FULL);
   assign bus.ex_valid      = (count_q != 2'd0);
   assign bus.ex_pc         = head.pc;
   assign bus.ex_opcode     = head.opcode;
   assign bus.ex_rd         = head.rd;
   assign bus.ex_rs1        = head.rs1;
   assign bus.ex_rs2        = head.rs2;
   assign bus.ex_funct3     = head.funct3;
   assign bus.ex_funct7     = head.funct7;
   assign bus.ex_imm        = head.imm;
   assign bus.ex_imm_funct3 = head.imm_funct3;
   assign bus.ex_illegal    = head.illegal;
   assign bus.issue_count   = issue_count_q;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - scoreboard bench for decode_issue_ctrl
module tb_decode_issue_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_issue_ctrl_if bus();
   decode_issue_ctrl #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [11:0] imm;
      logic [2:0]  imm_funct3;
      logic        illegal;
   } exp_t;

   exp_t        mq[$];
   logic [31:0] cnt_m = 32'd0;
   bit          started = 1'b0;
   int          preload_req = 0;
   int          preload_ack = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      e            = '0;
      e.pc         = pc;
      e.opcode     = inst[6:0];
      e.rd         = inst[11:7];
      e.rs1        = inst[19:15];
      e.rs2        = inst[24:20];
      e.funct3     = inst[14:12];
      e.funct7     = inst[31:25];
      e.imm_funct3 = (e.opcode == 7'h13) ? e.funct3 : 3'b000;
      if (e.opcode == 7'h13 || e.opcode == 7'h03 || e.opcode == 7'h67)
         e.imm = inst[31:20];
      else if (e.opcode == 7'h23)
         e.imm = {e.funct7, e.rd};
      else if (e.opcode == 7'h63)
         e.imm = {inst[31], inst[7], inst[30:25], inst[11:8]};
      else if (e.opcode == 7'h33)
         e.imm = 12'h000;
      else
         e.illegal = 1'b1;
      return e;
   endfunction

   // Reference model: advances on each clock edge, or immediately on a counter preload.
   initial begin
      forever begin
         @(posedge clk or preload_req);
         if (preload_req != preload_ack) begin
            cnt_m       = 32'hFFFF_FFFF;
            preload_ack = preload_req;
         end else if (rst) begin
            mq.delete();
            cnt_m   = 32'd0;
            started = 1'b1;
         end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (mq.size() != 0) && bus.ex_ready;
            do_push = bus.if_valid && (mq.size() < 2) && !bus.flush;
            if (do_pop) begin
               void'(mq.pop_front());
               cnt_m = cnt_m + 32'd1;
            end
            if (bus.flush) mq.delete();
            else if (do_push) mq.push_back(ref_decode(bus.if_inst, bus.if_pc));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         exp_t e;
         e = (mq.size() != 0) ? mq[0] : '0;
         chk("if_ready",      32'(bus.if_ready),      32'(mq.size() != 2));
         chk("ex_valid",      32'(bus.ex_valid),      32'(mq.size() != 0));
         chk("issue_count",   bus.issue_count,        cnt_m);
         chk("ex_pc",         bus.ex_pc,              e.pc);
         chk("ex_opcode",     32'(bus.ex_opcode),     32'(e.opcode));
         chk("ex_rd",         32'(bus.ex_rd),         32'(e.rd));
         chk("ex_rs1",        32'(bus.ex_rs1),        32'(e.rs1));
         chk("ex_rs2",        32'(bus.ex_rs2),        32'(e.rs2));
         chk("ex_funct3",     32'(bus.ex_funct3),     32'(e.funct3));
         chk("ex_funct7",     32'(bus.ex_funct7),     32'(e.funct7));
         chk("ex_imm",        32'(bus.ex_imm),        32'(e.imm));
         chk("ex_imm_funct3", 32'(bus.ex_imm_funct3), 32'(e.imm_funct3));
         chk("ex_illegal",    32'(bus.ex_illegal),    32'(e.illegal));
      end
   end

   task automatic step(input logic v, input logic [31:0] inst, input logic fl,
                       input logic er, input logic r);
      bus.if_valid = v;
      bus.if_inst  = inst;
      bus.if_pc    = pc_ctr;
      bus.flush    = fl;
      bus.ex_ready = er;
      rst          = r;
      pc_ctr       = pc_ctr + 32'd4;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic er);
      step(1'b0, 32'h0, 1'b0, er, 1'b0);
   endtask

   initial begin
      logic [6:0] ops [8];
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h33, 7'h37, 7'h6F};
      bus.if_valid = 1'b0;
      bus.if_inst  = 32'h0;
      bus.if_pc    = 32'h0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);

      step(1'b1, 32'hFFF0_0093, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      step(1'b1, 32'hFE11_2E23, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h0050_D093, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      step(1'b1, 32'h0030_8113, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0041_0193, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0051_8213, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0051_8213, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h0051_8213, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      step(1'b1, 32'h0020_A023, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0020_8463, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0033, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      step(1'b1, 32'h0000_0037, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      #1;
      force dut.issue_count_q = 32'hFFFF_FFFF;
      preload_req = preload_req + 1;
      #1;
      release dut.issue_count_q;
      @(posedge clk);
      #1;
      step(1'b1, 32'h0010_0067, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h0040_2283, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0011_0113, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h0022_0213, 1'b0, 1'b1, 1'b1);
      idle(1'b1);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         logic [31:0] inst;
         r    = $urandom();
         inst = {r[31:7], ops[$urandom_range(7, 0)]};
         step(1'($urandom_range(1, 0)), inst, ($urandom_range(19, 0) == 0),
              ($urandom_range(3, 0) != 0), 1'b0);
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
